// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind the execute-stage store/load port, with a
// busy/ready handshake for multi-cycle loads. Define DMEM_CLEAR_EN to zero the array on reset.
module data_mem_responder #(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wem,
    input  logic        re,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [AW-1:0] load_idx;
    logic [AW-1:0] next_load_idx;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          legal;
    logic          store_go;
    logic          load_done;
    logic          next_busy;
    logic          next_ack;
    logic          next_rvalid;
    logic          next_err;

    // Anything with stray low bits or set bits above the array is rejected rather than aliased.
    assign idx   = address[AW+1:2];
    assign legal = (address[1:0] == 2'b00) && ((address >> (AW + 2)) == 32'd0);

    always_comb begin
        next_state    = state;
        next_count    = count;
        next_load_idx = load_idx;
        next_busy     = busy;
        next_ack      = 1'b0;
        next_rvalid   = 1'b0;
        next_err      = 1'b0;
        store_go      = 1'b0;
        load_done     = 1'b0;
        case (state)
            IDLE: begin
                if (wem && re) begin
                    next_err = 1'b1;
                end else if ((wem || re) && !legal) begin
                    next_err = 1'b1;
                end else if (wem) begin
                    store_go = 1'b1;
                    next_ack = 1'b1;
                end else if (re) begin
                    next_load_idx = idx;
                    next_count    = CW'(RD_LAT - 1);
                    next_busy     = 1'b1;
                    next_state    = WAIT;
                end
            end
            WAIT: begin
                if (count != '0) begin
                    next_count = count - 1'b1;
                end else begin
                    load_done   = 1'b1;
                    next_rvalid = 1'b1;
                    next_busy   = 1'b0;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ack      <= 1'b0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            count    <= '0;
            load_idx <= '0;
        end else begin
            state    <= next_state;
            busy     <= next_busy;
            ack      <= next_ack;
            rvalid   <= next_rvalid;
            err      <= next_err;
            count    <= next_count;
            load_idx <= next_load_idx;
            if (load_done) begin
                rdata <= mem[load_idx];
            end
        end
    end

`ifdef DMEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_go) begin
            mem[idx] <= datain;
        end
    end
`else
    // Contents survive reset; only a store sampled out of reset may write.
    always_ff @(posedge clk) begin
        if (rst_n && store_go) begin
            mem[idx] <= datain;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array
// reference model; honours DMEM_CLEAR_EN for the reset-clears-memory expectation.
module tb_data_mem_responder;

    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wem = 1'b0;
    logic        re = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] datain = '0;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    logic [31:0] modelMem [DEPTH];
    logic [31:0] lastRdata = '0;
    int          checkCount = 0;
    int          errorCount = 0;

    // Flag vector order used by every flag comparison: {busy, ack, rvalid, err}.
    localparam logic [31:0] FLAGS_NONE  = 32'b0000;
    localparam logic [31:0] FLAGS_BUSY  = 32'b1000;
    localparam logic [31:0] FLAGS_ACK   = 32'b0100;
    localparam logic [31:0] FLAGS_VALID = 32'b0010;
    localparam logic [31:0] FLAGS_ERR   = 32'b0001;

    data_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wem    (wem),
        .re     (re),
        .address(address),
        .datain (datain),
        .busy   (busy),
        .ack    (ack),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wem     = w;
        re      = r;
        address = a;
        datain  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {28'b0, busy, ack, rvalid, err};
    endfunction

    function automatic bit isLegal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] randomAddress();
        int kind;
        kind = $urandom_range(0, 9);
        if (kind < 7) return 32'($urandom_range(0, DEPTH - 1) * 4);
        if (kind == 7) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        if (kind == 8) return 32'((DEPTH + $urandom_range(0, 1000)) * 4);
        return ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, " idle flags"}, flags(), FLAGS_NONE);
        checkOutput({tag, " rdata hold"}, rdata, lastRdata);
    endtask

    task automatic modelReset();
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
`endif
        lastRdata = '0;
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        if (isLegal(a)) begin
            modelMem[a / 4] = d;
            checkOutput("store ack", flags(), FLAGS_ACK);
        end else begin
            checkOutput("store err", flags(), FLAGS_ERR);
        end
        checkOutput("store rdata hold", rdata, lastRdata);
        tick();
        checkIdle("after store");
    endtask

    task automatic doBoth(input logic [31:0] a);
        applyStimulus(1'b1, 1'b1, a, $urandom());
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("both err", flags(), FLAGS_ERR);
        tick();
        checkIdle("after both");
    endtask

    // junkMode: 0 quiet wait, 1 random requests while busy, 2 store 0x5A5A5A5A to the loaded address while busy.
    task automatic doLoad(input logic [31:0] a, input int junkMode);
        applyStimulus(1'b0, 1'b1, a, $urandom());
        tick();
        if (!isLegal(a)) begin
            applyStimulus(1'b0, 1'b0, '0, '0);
            checkOutput("load err", flags(), FLAGS_ERR);
            tick();
            checkIdle("after bad load");
            return;
        end
        checkOutput("load accept busy", flags(), FLAGS_BUSY);
        for (int k = 1; k <= RD_LAT; k++) begin
            if (junkMode == 1) applyStimulus(1'($urandom()), 1'($urandom()), randomAddress(), $urandom());
            else if (junkMode == 2) applyStimulus(1'b1, 1'b0, a, 32'h5A5A_5A5A);
            else applyStimulus(1'b0, 1'b0, '0, '0);
            tick();
            if (k < RD_LAT) begin
                checkOutput("load wait busy", flags(), FLAGS_BUSY);
            end else begin
                checkOutput("load rvalid", flags(), FLAGS_VALID);
                checkOutput("load rdata", rdata, modelMem[a / 4]);
                lastRdata = modelMem[a / 4];
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkIdle("after load");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset flags", flags(), FLAGS_NONE);
        checkOutput("reset rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        checkIdle("post reset");

        // Give every word a known value so later loads have a defined expectation.
        for (int i = 0; i < DEPTH; i++) doStore(32'(i * 4), $urandom());

        doStore(32'h10, 32'hDEAD_BEEF);
        doLoad(32'h10, 0);
        checkOutput("deadbeef readback", lastRdata, 32'hDEAD_BEEF);

        doLoad(32'h13, 0);
        doStore(32'h100, 32'hCAFE_F00D);
        doLoad(32'h00, 0);

        doBoth(32'h20);
        doLoad(32'h20, 0);

        doLoad(32'h04, 2);
        doLoad(32'h04, 0);

        // Reset lands on the first WAIT edge of an accepted load.
        applyStimulus(1'b0, 1'b1, 32'h0C, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("abort accept busy", flags(), FLAGS_BUSY);
        rst_n = 1'b0;
        tick();
        modelReset();
        checkOutput("abort reset flags", flags(), FLAGS_NONE);
        checkOutput("abort reset rdata", rdata, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            tick();
            checkIdle("aborted load");
        end
        doLoad(32'h0C, 0);

        doStore(32'h08, 32'h1234_5678);
        rst_n = 1'b0;
        tick();
        modelReset();
        rst_n = 1'b1;
        tick();
        checkIdle("after reset pulse");
        doLoad(32'h08, 0);
`ifdef DMEM_CLEAR_EN
        checkOutput("cleared word", lastRdata, 32'h0);
`else
        checkOutput("persisted word", lastRdata, 32'h1234_5678);
`endif

        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) doStore(randomAddress(), $urandom());
            else if (op < 8) doLoad(randomAddress(), int'($urandom_range(0, 1)));
            else if (op == 8) doBoth(randomAddress());
            else begin
                tick();
                checkIdle("random idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the execute-stage store/load interface.
- Accepts store strobes (wem), load strobes (re), a byte address and store data from the execute-stage selector.
- Performs word accesses on an internal memory array and returns load data with a valid pulse for register-file write-back.
- A busy/ready handshake exposes the multi-cycle read latency to the requester.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; power of two, at least 2.
- RD_LAT, 2, clock edges from load acceptance to load data; at least 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wem  in  1  store request strobe.
- re  in  1  load request strobe.
- address  in  32  byte address, word-aligned.
- datain  in  32  store data.
- busy  out  1  load in flight; new requests are ignored while high.
- ack  out  1  one-cycle pulse: store completed.
- rdata  out  32  load data; holds its last value between loads.
- rvalid  out  1  one-cycle pulse: rdata valid.
- err  out  1  one-cycle pulse: request rejected.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n). While rst_n=0 at an edge: state=IDLE, busy=0, ack=0, rvalid=0, err=0, rdata=0, wait counter=0.
- Address decode:
  - idx = address[log2(DEPTH)+1:2].
  - Request is legal only if address[1:0]==0 and address[31:log2(DEPTH)+2]==0.
- FSM states: IDLE, WAIT.
- IDLE, request evaluation at each edge:
  - wem=1 and re=1 together: err=1 next cycle; no access.
  - Illegal address with wem or re set: err=1 next cycle; no access; no state change.
  - wem=1, legal: mem[idx]<=datain on this edge; ack=1 next cycle; stay IDLE. busy is never raised for a store.
  - re=1, legal: latch idx; counter<=RD_LAT-1; busy<=1; go to WAIT.
- WAIT:
  - Counter>0: decrement.
  - Counter==0 at an edge: rdata<=mem[latched idx]; rvalid<=1; busy<=0; go to IDLE.
- Latency:
  - Load accepted at edge E0 gives rvalid/rdata in the cycle after edge E0+RD_LAT.
  - busy is high for exactly RD_LAT cycles.
- Requests during WAIT are ignored entirely: no err, no ack, no memory write.
- A new request may be accepted on the same edge that returns rvalid only if it is sampled in IDLE, i.e. on the following edge. This gives back-to-back loads a throughput of one per RD_LAT+1 cycles.
- Load after store to the same word reads the new value, since the write completes at the acceptance edge.
- ack, rvalid and err are each one cycle wide and mutually exclusive in any cycle.
- Reset mid-load aborts the load: no rvalid, busy=0 next cycle, memory contents per Optional Feature.
- Address wrap-around does not exist: out-of-range addresses are rejected, never aliased.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined: reset also clears every memory word to 0 on the same reset edge.
- Not defined: memory is not touched by reset; contents persist across reset and are undefined after power-up. Reset affects only control state and outputs.

Test Plan:
- Store 0xDEADBEEF at 0x10, then load 0x10 with RD_LAT=2: ack=1 one cycle after the store edge. busy=1 for 2 cycles after load acceptance. rvalid=1 with rdata=0xDEADBEEF in the cycle after acceptance edge +2.
- Load at 0x13 (misaligned) and store at 0x100 (out of range, DEPTH=64): err pulses once per request. No rvalid, busy stays 0. A subsequent load of 0x00 returns its prior value, so no aliasing.
- wem=1 and re=1 together at 0x20: err=1 one cycle later. Load of 0x20 afterwards returns the unchanged value.
- Load 0x04 accepted, then store 0x5A5A5A5A at 0x04 while busy=1: store ignored, no ack. rvalid returns the old value, and a later load also returns the old value.
- rst_n=0 during the first WAIT cycle of a load: no rvalid ever appears. All outputs 0 the cycle after the reset edge, and a fresh load completes normally.
- Store 0x12345678 at 0x08, pulse reset, load 0x08: returns 0x00000000 with DMEM_CLEAR_EN defined, 0x12345678 without it.
